// File: rtl/chacha_pkg.sv
// ----------------------------------------------------------------------------
// chacha_pkg
// Definitions shared by the plaintext buffer and the ciphertext serializer on
// the ChaCha20 datapath.
//   DEF_DATA_SIZE    : bits per character
//   DEF_NUM_MATRICES : 64-byte keystream blocks per message buffer
//   DEF_NO_REG       : byte capacity of one message buffer
//   byte_t / idx_t   : character and address/count types at default sizing
//   ser_state_t      : serializer FSM encoding. Both buffers use it, so their
//                      debug state values read the same way.
// ----------------------------------------------------------------------------
package chacha_pkg;

    localparam int DEF_DATA_SIZE    = 8;
    localparam int DEF_NUM_MATRICES = 20;
    localparam int DEF_NO_REG       = 64 * DEF_NUM_MATRICES;
    localparam int DEF_IDX_W        = $clog2(DEF_NO_REG) + 1;

    typedef logic [DEF_DATA_SIZE-1:0] byte_t;
    typedef logic [DEF_IDX_W-1:0]     idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } ser_state_t;

endpackage

// File: rtl/cipher_text_serializer_if.sv
// ----------------------------------------------------------------------------
// cipher_text_serializer_if
// This interface bundles the block-capture inputs and the byte-stream outputs
// of the ciphertext serializer.
//   load/byte_count/block_in : parallel block capture request
//   out_ready                : downstream sink can take a byte
//   char_out/valid/last      : byte stream toward Poly1305 / output sink
//   busy/done                : block held / one-cycle completion pulse
//   dbg_state                : FSM state, for observation only
// Handshake: a byte transfers on a rising clk edge where char_valid and
// out_ready are both 1. While char_valid=1 and out_ready=0, char_out,
// char_valid and char_last hold. char_valid never depends on out_ready, and
// out_ready has no effect when char_valid=0.
// ----------------------------------------------------------------------------
interface cipher_text_serializer_if #(
    parameter int DATA_SIZE = chacha_pkg::DEF_DATA_SIZE,
    parameter int NO_REG    = chacha_pkg::DEF_NO_REG
);
    import chacha_pkg::*;

    localparam int IDX_W = $clog2(NO_REG) + 1;

    logic                 load;
    logic [IDX_W-1:0]     byte_count;
    logic [DATA_SIZE-1:0] block_in [NO_REG];
    logic                 out_ready;
    logic [DATA_SIZE-1:0] char_out;
    logic                 char_valid;
    logic                 char_last;
    logic                 busy;
    logic                 done;
    ser_state_t           dbg_state;

    modport master (
        output load, byte_count, block_in, out_ready,
        input  char_out, char_valid, char_last, busy, done, dbg_state
    );

    modport slave (
        input  load, byte_count, block_in, out_ready,
        output char_out, char_valid, char_last, busy, done, dbg_state
    );

endinterface

// File: rtl/cipher_text_serializer.sv
// ----------------------------------------------------------------------------
// cipher_text_serializer
// This module captures a full parallel ciphertext block (plaintext XOR
// keystream) in one cycle. It then streams the first len bytes out one per
// beat, where len = min(byte_count, NO_REG).
//   clk, rst : clock; synchronous active-high reset
//   ser      : cipher_text_serializer_if.slave (capture in, byte stream out)
// Timing: when a load is accepted at edge N, the first byte is valid in cycle
// N+1. With out_ready held high, done pulses in cycle N+len+1. An empty load
// (byte_count=0) pulses done in cycle N+1 and produces no beats.
// ----------------------------------------------------------------------------
module cipher_text_serializer #(
    parameter int NUM_MATRICES = chacha_pkg::DEF_NUM_MATRICES,
    parameter int DATA_SIZE    = chacha_pkg::DEF_DATA_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    cipher_text_serializer_if.slave ser
);
    import chacha_pkg::*;

    localparam int NO_REG = 64 * NUM_MATRICES;
    localparam int IDX_W  = $clog2(NO_REG) + 1;
    localparam int AW     = $clog2(NO_REG);
    localparam logic [IDX_W-1:0] NO_REG_I = IDX_W'(NO_REG);
    localparam logic [IDX_W-1:0] ONE_I    = IDX_W'(1);

    ser_state_t           state_q, state_d;
    logic [IDX_W-1:0]     rd_addr_q, rd_addr_d;
    logic [IDX_W-1:0]     len_q, len_d;
    logic [DATA_SIZE-1:0] char_out_q, char_out_d;
    logic                 char_last_q, char_last_d;
    logic [DATA_SIZE-1:0] mem_q [NO_REG];

    logic                 capture;
    logic [IDX_W-1:0]     len_in;
    logic [IDX_W-1:0]     next_addr;

    // Oversized counts are clamped to the storage capacity.
    assign len_in    = (ser.byte_count > NO_REG_I) ? NO_REG_I : ser.byte_count;
    assign next_addr = rd_addr_q + ONE_I;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        len_d       = len_q;
        char_out_d  = char_out_q;
        char_last_d = char_last_q;
        capture     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ser.load) begin
                    if (len_in != '0) begin
                        capture     = 1'b1;
                        len_d       = len_in;
                        rd_addr_d   = '0;
                        // Byte 0 goes straight into the output register at
                        // capture, so the first beat is valid the next cycle.
                        char_out_d  = ser.block_in[0];
                        char_last_d = (len_in == ONE_I);
                        state_d     = STREAM;
                    end else begin
                        state_d     = FINISH;
                    end
                end
            end
            STREAM: begin
                if (ser.out_ready) begin
                    if (char_last_q) begin
                        char_last_d = 1'b0;
                        state_d     = FINISH;
                    end else begin
                        // next_addr <= len-1 <= NO_REG-1, so the truncated
                        // index cannot wrap.
                        rd_addr_d   = next_addr;
                        char_out_d  = mem_q[next_addr[AW-1:0]];
                        char_last_d = (next_addr == (len_q - ONE_I));
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            len_q       <= '0;
            char_out_q  <= '0;
            char_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            len_q       <= len_d;
            char_out_q  <= char_out_d;
            char_last_q <= char_last_d;
        end
    end

    // Storage has no reset: it is always rewritten before it is read.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q <= ser.block_in;
        end
    end

    assign ser.char_out   = char_out_q;
    assign ser.char_valid = (state_q == STREAM);
    assign ser.char_last  = char_last_q;
    assign ser.busy       = (state_q != IDLE);
    assign ser.done       = (state_q == FINISH);
    assign ser.dbg_state  = state_q;

endmodule

// File: tb/tb_cipher_text_serializer.sv
module tb_cipher_text_serializer;
    import chacha_pkg::*;

    localparam int NR = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cipher_text_serializer_if #(.DATA_SIZE(8), .NO_REG(NR)) bus ();

    cipher_text_serializer #(.NUM_MATRICES(1), .DATA_SIZE(8)) dut (
        .clk (clk),
        .rst (rst),
        .ser (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] exp_q[$];          // {last, byte}
    logic       pending_done = 1'b0;
    logic       empty_pend   = 1'b0;
    logic       mon_en       = 1'b0;
    int         beats_seen   = 0;
    logic [7:0] blk [NR];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge. A beat at the front
    // of the queue is popped only when it actually transfers.
    always @(negedge clk) begin
        logic [8:0] item;
        if (mon_en && !rst) begin
            check("done", {31'd0, bus.done}, {31'd0, pending_done});
            pending_done = empty_pend;
            empty_pend   = 1'b0;
            if (bus.char_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    check("char_out", {24'd0, bus.char_out}, {24'd0, exp_q[0][7:0]});
                    check("char_last", {31'd0, bus.char_last}, {31'd0, exp_q[0][8]});
                    if (bus.out_ready) begin
                        item = exp_q.pop_front();
                        if (item[8]) pending_done = 1'b1;
                        beats_seen++;
                    end
                end
            end
        end
    end

    // Drive one load cycle from blk; the caller is one step after a posedge.
    task automatic do_load(input int cnt);
        int n;
        n = (cnt > NR) ? NR : cnt;
        bus.load       = 1'b1;
        bus.byte_count = 7'(cnt);
        bus.block_in   = blk;
        if (n == 0) empty_pend = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), blk[i]});
        @(posedge clk); #1;
        bus.load = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || pending_done || empty_pend) && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_timeout"}, {31'd0, (cyc >= 500)}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int start;
        int cyc;
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

        // Clock/reset
        rst = 1'b1;
        bus.load = 1'b0;
        bus.byte_count = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NR; i++) blk[i] = 8'h00;
        bus.block_in = blk;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", {31'd0, bus.char_valid}, 32'd0);
        check("rst_last", {31'd0, bus.char_last}, 32'd0);
        check("rst_out", {24'd0, bus.char_out}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_state", {30'd0, bus.dbg_state}, {30'd0, IDLE});
        mon_en = 1'b1;

        // Full block, out_ready high throughout.
        bus.out_ready = 1'b1;
        for (int i = 0; i < NR; i++) blk[i] = 8'(i) ^ 8'hA5;
        start = beats_seen;
        do_load(64);
        check("first_valid", {31'd0, bus.char_valid}, 32'd1);
        check("first_busy", {31'd0, bus.busy}, 32'd1);
        wait_done("full");
        check("full_beats", beats_seen - start, 32'd64);

        // Backpressure pattern.
        blk[0] = 8'h11; blk[1] = 8'h22; blk[2] = 8'h33; blk[3] = 8'h44;
        start = beats_seen;
        do_load(4);
        for (int k = 0; k < 7; k++) begin
            bus.out_ready = pat[k][0];
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        wait_done("bp");
        check("bp_beats", beats_seen - start, 32'd4);

        // Empty block: no beats, done in the cycle after the load.
        start = beats_seen;
        do_load(0);
        check("empty_done", {31'd0, bus.done}, 32'd1);
        check("empty_valid", {31'd0, bus.char_valid}, 32'd0);
        wait_done("empty");
        check("empty_beats", beats_seen - start, 32'd0);

        // Oversized count is clamped to 64 beats.
        for (int i = 0; i < NR; i++) blk[i] = 8'($urandom_range(0, 255));
        start = beats_seen;
        do_load(100);
        wait_done("clamp");
        check("clamp_beats", beats_seen - start, 32'd64);

        // Load held high while busy is ignored; the reload right after done is taken.
        for (int i = 0; i < NR; i++) blk[i] = 8'($urandom_range(0, 255));
        start = beats_seen;
        do_load(10);
        for (int i = 0; i < NR; i++) blk[i] = 8'($urandom_range(0, 255));
        bus.load = 1'b1;
        bus.byte_count = 7'd10;
        bus.block_in = blk;
        for (int k = 0; k < 11; k++) begin
            check("busy_hold", {31'd0, bus.busy}, 32'd1);
            @(posedge clk); #1;
        end
        bus.load = 1'b0;
        wait_done("busy");
        check("busy_beats", beats_seen - start, 32'd10);
        start = beats_seen;
        do_load(10);
        wait_done("reload");
        check("reload_beats", beats_seen - start, 32'd10);

        // Reset after beat 5 of 20, then a fresh load.
        for (int i = 0; i < NR; i++) blk[i] = 8'($urandom_range(0, 255));
        start = beats_seen;
        do_load(20);
        cyc = 0;
        while (beats_seen - start < 5 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_mid_timeout", {31'd0, (cyc >= 100)}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        pending_done = 1'b0;
        empty_pend = 1'b0;
        check("mid_rst_valid", {31'd0, bus.char_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        check("mid_rst_state", {30'd0, bus.dbg_state}, {30'd0, IDLE});
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) blk[i] = 8'($urandom_range(0, 255));
        start = beats_seen;
        do_load(20);
        wait_done("after_rst");
        check("after_rst_beats", beats_seen - start, 32'd20);

        // Random backpressure.
        for (int i = 0; i < NR; i++) blk[i] = 8'($urandom_range(0, 255));
        start = beats_seen;
        do_load(30);
        cyc = 0;
        while ((exp_q.size() != 0 || pending_done) && cyc < 1000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        bus.out_ready = 1'b1;
        check("rand_timeout", {31'd0, (cyc >= 1000)}, 32'd0);
        check("rand_beats", beats_seen - start, 32'd30);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
